mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WA, default 8, number of unpacked array entries (address dimension size), WA >= 2.
REQ-002 Parameter WB, default 8, entry width in bits (bit dimension size), WB >= 1.
REQ-003 Parameter WI, default 3, address port width, SHALL satisfy 2**WI >= WA.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 rN_vld  input  1  request valid, requester N (N = 0,1).
REQ-007 rN_wen  input  1  1 = write, 0 = read.
REQ-008 rN_adr  input  WI  entry address.
REQ-009 rN_wdt  input  WB  write data.
REQ-010 rN_rdy  output  1  grant; transfer occurs when rN_vld & rN_rdy.
REQ-011 rN_rvl  output  1  read data valid pulse.
REQ-012 rN_rdt  output  WB  read data.
REQ-013 busy  output  1  initialization sweep in progress.

Function
REQ-014 Storage SHALL be an internal unpacked array of WA entries, WB bits each, index 0 to WA-1.
REQ-015 FSM SHALL have two states, INIT and RUN; reset enters INIT with sweep counter cnt = 0.
REQ-016 INIT: each cycle writes all-zero to entry cnt and increments cnt; after writing entry WA-1, next state RUN; INIT lasts exactly WA cycles.
REQ-017 INIT: busy = 1, r0_rdy = r1_rdy = 0; RUN: busy = 0.
REQ-018 RUN: at most one grant per cycle; rN_rdy is combinational from rN_vld, priority pointer prio, and state.
REQ-019 Only one rN_vld high: that requester granted in the same cycle.
REQ-020 Both rN_vld high: requester prio granted.
REQ-021 After any transfer, prio SHALL point to the non-granted requester; with no transfer, prio unchanged.
REQ-022 Requester SHALL hold vld, wen, adr, wdt stable until granted; the block does not check this.
REQ-023 Write transfer: entry adr updated at the granting clock edge.
REQ-024 Read transfer: rN_rdt registered at granting edge, rN_rvl = 1 for exactly the following cycle; rN_rdt holds value until the next read by that requester.
REQ-025 Read of an address written in the immediately preceding cycle SHALL return the new data.
REQ-026 Address adr >= WA: write dropped, read completes normally with rN_rdt = all-zero.
REQ-027 Back-to-back transfers by one requester SHALL be sustained at one per cycle when the other is idle.
REQ-028 Round-robin SHALL alternate grants 0,1,0,1 under continuous dual request; no requester waits more than one cycle.

Reset
REQ-029 rst_n low SHALL immediately force: state INIT, cnt = 0, prio = 0, rN_rdy = 0, rN_rvl = 0, rN_rdt = 0, busy = 1.
REQ-030 Reset mid-operation SHALL abort any pending read response (no rN_rvl) and re-run the full INIT sweep after release; all entries read zero afterwards.
REQ-031 Array contents are not reset asynchronously; clearing is solely by the INIT sweep.

Verification
REQ-032 Release reset, both vld high -> busy = 1 and rdy = 0 for 8 cycles (WA = 8), then r0_rdy = 1 first cycle of RUN.
REQ-033 r0 writes entry a = 3 with 8'h03 -> r1 reads entry 3 next cycle -> r1_rvl pulse one cycle later, r1_rdt = 8'h03.
REQ-034 Both requesters read continuously for 6 cycles -> grants 0,1,0,1,0,1, each rvl one cycle after its grant.
REQ-035 Write entries 0..7 with value a, read all -> rdt = a for each; read adr 8 (WI = 4, WA = 8) -> rdt = 0, no entry modified.
REQ-036 Assert rst_n low one cycle after a read grant -> no rvl, busy = 1, INIT reruns, all 8 entries read 0.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Requester-side bus of the two-port memory arbiter: request, grant and
// read-response signals for one requester.
interface mem_arbiter_if #(
  parameter int WI = 3,
  parameter int WB = 8
);
  logic          vld;
  logic          wen;
  logic [WI-1:0] adr;
  logic [WB-1:0] wdt;
  logic          rdy;
  logic          rvl;
  logic [WB-1:0] rdt;

  modport master (
    output vld, wen, adr, wdt,
    input  rdy, rvl, rdt
  );

  modport slave (
    input  vld, wen, adr, wdt,
    output rdy, rvl, rdt
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of a small register array.
// After reset the array is swept to zero, one entry per cycle, before any
// request is granted.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_INIT | zero sweep: entry cnt cleared each cycle, no grants, busy=1
// ST_RUN  | normal operation: one grant per cycle, round-robin on tie
module mem_arbiter #(
  parameter int WA = 8,
  parameter int WB = 8,
  parameter int WI = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  mem_arbiter_if.slave    r0,
  mem_arbiter_if.slave    r1,
  output logic            busy
);

  localparam int              AW       = $clog2(WA);
  localparam logic [AW-1:0]   CNT_LAST = AW'(WA - 1);
  localparam logic [WI:0]     WA_EXT   = (WI + 1)'(WA);

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  state_t        state;
  logic [AW-1:0] cnt;
  logic          prio;

  logic [WB-1:0] mem [WA];

  logic          run;
  logic          gnt0;
  logic          gnt1;
  logic          xfer;
  logic          x_wen;
  logic [WI-1:0] x_adr;
  logic [WB-1:0] x_wdt;
  logic          x_in_range;
  logic [AW-1:0] x_idx;
  logic [WB-1:0] rd_data;

  assign run  = (state == ST_RUN);
  assign busy = ~run;

  // Grant: a lone requester wins immediately, on a tie prio decides.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (run) begin
      gnt0 = r0.vld & (~r1.vld | (prio == 1'b0));
      gnt1 = r1.vld & (~r0.vld | (prio == 1'b1));
    end
  end

  assign r0.rdy = gnt0;
  assign r1.rdy = gnt1;

  // Only one grant can be active, so a single shared access path suffices.
  always_comb begin
    xfer  = gnt0 | gnt1;
    x_wen = gnt1 ? r1.wen : r0.wen;
    x_adr = gnt1 ? r1.adr : r0.adr;
    x_wdt = gnt1 ? r1.wdt : r0.wdt;
  end

  assign x_in_range = ({1'b0, x_adr} < WA_EXT);
  assign x_idx      = x_adr[AW-1:0];

  // Out-of-range reads return zero rather than aliasing onto a real entry.
  always_comb begin
    rd_data = '0;
    if (x_in_range) begin
      rd_data = mem[x_idx];
    end
  end

  // Array write port; no reset so contents are cleared only by the sweep.
  always_ff @(posedge clk) begin
    if (state == ST_INIT) begin
      mem[cnt] <= '0;
    end else if (xfer && x_wen && x_in_range) begin
      mem[x_idx] <= x_wdt;
    end
  end

  // Sequencing FSM, round-robin pointer and registered read responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_INIT;
      cnt    <= '0;
      prio   <= 1'b0;
      r0.rvl <= 1'b0;
      r1.rvl <= 1'b0;
      r0.rdt <= '0;
      r1.rdt <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          if (cnt == CNT_LAST) begin
            state <= ST_RUN;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RUN: begin
          if (gnt0) begin
            prio <= 1'b1;
          end else if (gnt1) begin
            prio <= 1'b0;
          end
        end
        default: begin
          state <= ST_INIT;
          cnt   <= '0;
        end
      endcase

      r0.rvl <= gnt0 & ~r0.wen;
      r1.rvl <= gnt1 & ~r1.wen;
      if (gnt0 && !r0.wen) begin
        r0.rdt <= rd_data;
      end
      if (gnt1 && !r1.wen) begin
        r1.rdt <= rd_data;
      end
    end
  end

endmodule
